// File: rtl/alu_operand_exec_pkg.sv
// Shared definitions for the operand/ALU front end and the downstream display stage.
package alu_operand_exec_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOR = 3'b011,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101,
    OP_SLT = 3'b110,
    OP_SLL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_SHOW = 2'd2
  } state_e;

  typedef struct packed {
    logic signed [DATA_W-1:0] f;
    logic                     of;
  } alu_res_t;

endpackage

// File: rtl/alu_operand_exec_if.sv
// Board-side bundle: raw buttons and switches in, registered ALU result and status out.
interface alu_operand_exec_if;
  logic                                   btn_load;
  logic                                   btn_go;
  logic [7:0]                             sw_data;
  logic [1:0]                             sw_byte;
  logic                                   sw_sel_ab;
  logic [2:0]                             sw_op;
  logic [alu_operand_exec_pkg::DATA_W-1:0] F;
  logic                                   ZF;
  logic                                   OF;
  logic                                   res_valid;
  logic                                   busy;

  modport master (
    output btn_load, btn_go, sw_data, sw_byte, sw_sel_ab, sw_op,
    input  F, ZF, OF, res_valid, busy
  );

  modport slave (
    input  btn_load, btn_go, sw_data, sw_byte, sw_sel_ab, sw_op,
    output F, ZF, OF, res_valid, busy
  );
endinterface

// File: rtl/alu_operand_exec_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, one-cycle pulse on press.
module btn_debounce #(
  parameter int DEB_CYCLES = 500000,
  parameter int DEB_W      = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pulse
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic [DEB_W-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // Level accepted; only a press (0->1) produces the pulse.
      level_d = ~level_q;
      cnt_d   = '0;
      pulse_d = ~level_q;
    end else begin
      cnt_d = cnt_q + DEB_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/alu_operand_exec.sv
// Operand assembly from switches, one ALU operation per GO press, registered F/ZF/OF.
module alu_operand_exec
  import alu_operand_exec_pkg::*;
#(
  parameter int DEB_CYCLES = 500000,
  parameter int DEB_W      = 20
) (
  input logic               clk,
  input logic               rst,
  alu_operand_exec_if.slave io
);

  function automatic alu_res_t alu_exec(input alu_op_e op,
                                        input logic signed [DATA_W-1:0] a,
                                        input logic signed [DATA_W-1:0] b);
    alu_res_t r;
    r.f  = '0;
    r.of = 1'b0;
    case (op)
      OP_AND: r.f = a & b;
      OP_OR:  r.f = a | b;
      OP_XOR: r.f = a ^ b;
      OP_NOR: r.f = ~(a | b);
      OP_ADD: begin
        r.f  = a + b;
        r.of = (a[DATA_W-1] == b[DATA_W-1]) && (r.f[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        r.f  = a - b;
        r.of = (a[DATA_W-1] != b[DATA_W-1]) && (r.f[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SLT: r.f = (a < b) ? DATA_W'(1) : '0;
      OP_SLL: r.f = b << a[4:0];
      default: r.f = '0;
    endcase
    return r;
  endfunction

  logic load_p, go_p;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_load (
    .clk(clk), .rst(rst), .btn_raw(io.btn_load), .pulse(load_p)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_go (
    .clk(clk), .rst(rst), .btn_raw(io.btn_go), .pulse(go_p)
  );

  state_e                   state_q, state_d;
  alu_op_e                  op_q,    op_d;
  logic signed [DATA_W-1:0] a_q,     a_d;
  logic signed [DATA_W-1:0] b_q,     b_d;
  logic signed [DATA_W-1:0] f_q,     f_d;
  logic                     zf_q,    zf_d;
  logic                     of_q,    of_d;
  logic                     do_load;
  alu_res_t                 alu_r;

  always_comb begin
    alu_r   = alu_exec(op_q, a_q, b_q);
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    f_d     = f_q;
    zf_d    = zf_q;
    of_d    = of_q;
    do_load = 1'b0;
    // Load outranks GO when both pulses land together; pulses in EXEC are dropped.
    case (state_q)
      ST_IDLE: begin
        if (load_p) begin
          do_load = 1'b1;
        end else if (go_p) begin
          op_d    = alu_op_e'(io.sw_op);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        f_d     = alu_r.f;
        zf_d    = (alu_r.f == '0);
        of_d    = alu_r.of;
        state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (load_p) begin
          do_load = 1'b1;
          state_d = ST_IDLE;
        end else if (go_p) begin
          op_d    = alu_op_e'(io.sw_op);
          state_d = ST_EXEC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (do_load) begin
      if (io.sw_sel_ab) b_d[{io.sw_byte, 3'b000} +: 8] = io.sw_data;
      else              a_d[{io.sw_byte, 3'b000} +: 8] = io.sw_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_AND;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      zf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f_q     <= f_d;
      zf_q    <= zf_d;
      of_q    <= of_d;
    end
  end

  assign io.F         = f_q;
  assign io.ZF        = zf_q;
  assign io.OF        = of_q;
  assign io.res_valid = (state_q == ST_SHOW);
  assign io.busy      = (state_q == ST_EXEC);

endmodule

// File: tb/tb_alu_operand_exec.sv
// Directed bench for alu_operand_exec with a result scoreboard and a decoupled monitor.
module tb_alu_operand_exec;
  import alu_operand_exec_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_operand_exec_if io();

  alu_operand_exec #(.DEB_CYCLES(4), .DEB_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .io (io.slave)
  );

  typedef struct packed {
    logic [31:0] f;
    logic        zf;
    logic        of;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every fresh result (res_valid rising) is matched against the scoreboard.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (io.res_valid === 1'b1 && prev !== 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got F=%h, expected no result", io.F);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("result_F",  io.F,  e.f);
          chk("result_ZF", io.ZF, 32'(e.zf));
          chk("result_OF", io.OF, 32'(e.of));
        end
      end
      prev = io.res_valid;
    end
  end

  task automatic load(input logic sel, input logic [1:0] lane, input logic [7:0] d,
                      input int hold = 8);
    io.sw_sel_ab = sel;
    io.sw_byte   = lane;
    io.sw_data   = d;
    io.btn_load  = 1'b1;
    cyc(hold);
    io.btn_load  = 1'b0;
    cyc(8);
  endtask

  task automatic load_word(input logic sel, input logic [31:0] w);
    for (int i = 0; i < 4; i++) load(sel, 2'(i), w[i*8 +: 8]);
  endtask

  task automatic go(input logic [2:0] op, input logic [31:0] exp_f, input logic exp_of);
    exp_t e;
    int   n;
    e.f  = exp_f;
    e.zf = (exp_f == 32'h0);
    e.of = exp_of;
    sb_q.push_back(e);
    io.sw_op  = op;
    io.btn_go = 1'b1;
    n = 0;
    while (io.busy !== 1'b1 && n < 20) begin
      cyc(1);
      n++;
    end
    chk("go_busy_seen", 32'(io.busy), 32'd1);
    chk("go_rv_in_exec", 32'(io.res_valid), 32'd0);
    cyc(1);
    chk("go_rv_after_exec", 32'(io.res_valid), 32'd1);
    chk("go_busy_after_exec", 32'(io.busy), 32'd0);
    io.btn_go = 1'b0;
    cyc(8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    rst          = 1'b1;
    io.btn_load  = 1'b0;
    io.btn_go    = 1'b0;
    io.sw_data   = 8'h00;
    io.sw_byte   = 2'd0;
    io.sw_sel_ab = 1'b0;
    io.sw_op     = 3'd0;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    chk("reset_F",         io.F, 32'h0);
    chk("reset_ZF",        32'(io.ZF), 32'd0);
    chk("reset_OF",        32'(io.OF), 32'd0);
    chk("reset_res_valid", 32'(io.res_valid), 32'd0);
    chk("reset_busy",      32'(io.busy), 32'd0);

    // Byte assembly of A; result register untouched by loads.
    load_word(1'b0, 32'h12345678);
    chk("load_F_held",  io.F, 32'h0);
    chk("load_rv_low",  32'(io.res_valid), 32'd0);
    go(OP_OR, 32'h12345678, 1'b0);

    // Signed overflow on ADD.
    load_word(1'b0, 32'h7FFFFFFF);
    load_word(1'b1, 32'h00000001);
    go(OP_ADD, 32'h80000000, 1'b1);

    // SUB to zero, then signed SLT with a negative A.
    load_word(1'b0, 32'h00000005);
    load_word(1'b1, 32'h00000005);
    go(OP_SUB, 32'h0, 1'b0);
    load_word(1'b0, 32'hFFFFFFFF);
    load_word(1'b1, 32'h00000001);
    go(OP_SLT, 32'h1, 1'b0);

    // Short glitch must not load; a long press loads once.
    io.sw_sel_ab = 1'b0;
    io.sw_byte   = 2'd0;
    io.sw_data   = 8'h00;
    io.btn_load  = 1'b1;
    cyc(3);
    io.btn_load  = 1'b0;
    cyc(10);
    chk("glitch_rv_held", 32'(io.res_valid), 32'd1);
    go(OP_OR, 32'hFFFFFFFF, 1'b0);
    load(1'b0, 2'd0, 8'h00, 10);
    chk("long_press_rv_low", 32'(io.res_valid), 32'd0);
    go(OP_AND, 32'h0, 1'b0);
    go(OP_OR, 32'hFFFFFF01, 1'b0);

    // LOAD from SHOW returns to IDLE with F held.
    io.sw_sel_ab = 1'b0;
    io.sw_byte   = 2'd1;
    io.sw_data   = 8'h00;
    io.btn_load  = 1'b1;
    n = 0;
    while (io.res_valid !== 1'b0 && n < 20) begin
      cyc(1);
      n++;
    end
    chk("show_load_rv", 32'(io.res_valid), 32'd0);
    chk("show_load_F",  io.F, 32'hFFFFFF01);
    chk("show_load_busy", 32'(io.busy), 32'd0);
    io.btn_load = 1'b0;
    cyc(8);

    // Simultaneous LOAD and GO: write happens, no EXEC.
    io.sw_sel_ab = 1'b1;
    io.sw_byte   = 2'd1;
    io.sw_data   = 8'h02;
    io.sw_op     = OP_ADD;
    io.btn_load  = 1'b1;
    io.btn_go    = 1'b1;
    seen = 0;
    repeat (16) begin
      cyc(1);
      if (io.busy === 1'b1) seen = 1;
    end
    io.btn_load = 1'b0;
    io.btn_go   = 1'b0;
    cyc(8);
    chk("both_no_exec", 32'(seen), 32'd0);
    chk("both_rv_low",  32'(io.res_valid), 32'd0);
    go(OP_ADD, 32'hFFFF0201, 1'b0);

    // Reset landing on the EXEC cycle discards the result.
    io.sw_op  = OP_SLL;
    io.btn_go = 1'b1;
    n = 0;
    while (io.busy !== 1'b1 && n < 20) begin
      cyc(1);
      n++;
    end
    chk("rst_exec_busy", 32'(io.busy), 32'd1);
    rst       = 1'b1;
    io.btn_go = 1'b0;
    cyc(1);
    rst = 1'b0;
    chk("rst_exec_F",    io.F, 32'h0);
    chk("rst_exec_ZF",   32'(io.ZF), 32'd0);
    chk("rst_exec_OF",   32'(io.OF), 32'd0);
    chk("rst_exec_rv",   32'(io.res_valid), 32'd0);
    chk("rst_exec_busy_low", 32'(io.busy), 32'd0);
    cyc(8);
    load(1'b0, 2'd0, 8'h03);
    load(1'b1, 2'd0, 8'h01);
    go(OP_SLL, 32'h8, 1'b0);

    cyc(5);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
